// File: rtl/uve_regfile_banked.sv
// Banked UVE vector/predicate register file: registered reads, byte-enabled writes,
// busy scoreboard and bulk-clear FSM. Define UVE_RF_BYPASS_EN for same-cycle write forwarding.
module uve_regfile_banked #(
  parameter int unsigned NR_VREGS     = 32,
  parameter int unsigned NR_PREGS     = 16,
  parameter int unsigned VLEN         = 256,
  parameter int unsigned PLEN         = VLEN / 8,
  parameter int unsigned NR_VREAD     = 3,
  parameter int unsigned NR_PREAD     = 2,
  parameter int unsigned NR_WRITE     = 2,
  parameter bit          P0_HARDWIRED = 1'b1,
  localparam int unsigned VAW         = $clog2(NR_VREGS),
  localparam int unsigned PAW         = $clog2(NR_PREGS),
  localparam int unsigned VBYTES      = VLEN / 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NR_VREAD*VAW-1:0]    v_raddr_i,
  output logic [NR_VREAD*VLEN-1:0]   v_rdata_o,
  input  logic [NR_PREAD*PAW-1:0]    p_raddr_i,
  output logic [NR_PREAD*PLEN-1:0]   p_rdata_o,
  input  logic [NR_WRITE-1:0]        v_wvalid_i,
  output logic                       w_ready_o,
  input  logic [NR_WRITE*VAW-1:0]    v_waddr_i,
  input  logic [NR_WRITE*VLEN-1:0]   v_wdata_i,
  input  logic [NR_WRITE*VBYTES-1:0] v_wbe_i,
  input  logic [NR_WRITE-1:0]        v_wlast_i,
  input  logic [NR_WRITE-1:0]        p_we_i,
  input  logic [NR_WRITE*PAW-1:0]    p_waddr_i,
  input  logic [NR_WRITE*PLEN-1:0]   p_wdata_i,
  input  logic                       busy_set_i,
  input  logic [VAW-1:0]             busy_set_addr_i,
  output logic [NR_VREGS-1:0]        v_busy_o,
  input  logic                       clr_req_i,
  output logic                       clr_busy_o,
  output logic                       clr_done_o
);

  localparam int unsigned VDEPTH = 2 ** VAW;
  localparam int unsigned PDEPTH = 2 ** PAW;

  typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

  state_e              state_q, state_d;
  logic [VAW-1:0]      cnt_q, cnt_d;
  logic [NR_VREGS-1:0] busy_q, busy_d, busy_clr;
  logic                w_ready;

  logic [VLEN-1:0] vreg_q  [NR_VREGS];
  logic [VLEN-1:0] vreg_wr [NR_VREGS];
  logic [VLEN-1:0] vreg_d  [NR_VREGS];
  logic [PLEN-1:0] preg_q  [NR_PREGS];
  logic [PLEN-1:0] preg_wr [NR_PREGS];
  logic [PLEN-1:0] preg_d  [NR_PREGS];

  logic [NR_VREAD*VLEN-1:0] v_rdata_q, v_rdata_d;
  logic [NR_PREAD*PLEN-1:0] p_rdata_q, p_rdata_d;

  logic [VAW-1:0] v_raddr [NR_VREAD];
  logic [PAW-1:0] p_raddr [NR_PREAD];
  logic [VAW-1:0] v_waddr [NR_WRITE];
  logic [PAW-1:0] p_waddr [NR_WRITE];

  // Address-in-range lookup tables; out-of-range writes are dropped and reads return 0.
  logic [VDEPTH-1:0] vaddr_ok;
  logic [VDEPTH-1:0] pclr_ok;
  logic [PDEPTH-1:0] paddr_ok;

  for (genvar k = 0; k < VDEPTH; k++) begin : g_vok
    assign vaddr_ok[k] = (k < NR_VREGS);
    assign pclr_ok[k]  = (k < NR_PREGS);
  end
  for (genvar k = 0; k < PDEPTH; k++) begin : g_pok
    assign paddr_ok[k] = (k < NR_PREGS);
  end

  for (genvar i = 0; i < NR_VREAD; i++) begin : g_vra
    assign v_raddr[i] = v_raddr_i[i*VAW +: VAW];
  end
  for (genvar i = 0; i < NR_PREAD; i++) begin : g_pra
    assign p_raddr[i] = p_raddr_i[i*PAW +: PAW];
  end
  for (genvar j = 0; j < NR_WRITE; j++) begin : g_wa
    assign v_waddr[j] = v_waddr_i[j*VAW +: VAW];
    assign p_waddr[j] = p_waddr_i[j*PAW +: PAW];
  end

  // Clear FSM
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    w_ready    = 1'b0;
    clr_busy_o = 1'b0;
    clr_done_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        w_ready = 1'b1;
        if (clr_req_i) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        clr_busy_o = 1'b1;
        if (cnt_q == VAW'(NR_VREGS - 1)) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + VAW'(1);
        end
      end
      StDone: begin
        clr_busy_o = 1'b1;
        clr_done_o = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign w_ready_o = w_ready;

  // Port writes applied in ascending order so the highest port index wins per byte.
  always_comb begin
    vreg_wr  = vreg_q;
    preg_wr  = preg_q;
    busy_clr = '0;
    for (int j = 0; j < NR_WRITE; j++) begin
      if (v_wvalid_i[j] && w_ready && vaddr_ok[v_waddr[j]]) begin
        for (int b = 0; b < VBYTES; b++) begin
          if (v_wbe_i[j*VBYTES + b]) begin
            vreg_wr[v_waddr[j]][b*8 +: 8] = v_wdata_i[j*VLEN + b*8 +: 8];
          end
        end
        if (v_wlast_i[j]) begin
          busy_clr[v_waddr[j]] = 1'b1;
        end
      end
      if (p_we_i[j] && w_ready && paddr_ok[p_waddr[j]] &&
          !(P0_HARDWIRED && (p_waddr[j] == '0))) begin
        preg_wr[p_waddr[j]] = p_wdata_i[j*PLEN +: PLEN];
      end
    end
  end

  // Next state: writes, scoreboard (set beats last-write clear), then one clear step.
  always_comb begin
    vreg_d = vreg_wr;
    preg_d = preg_wr;
    busy_d = busy_q & ~busy_clr;
    if (busy_set_i && w_ready && vaddr_ok[busy_set_addr_i]) begin
      busy_d[busy_set_addr_i] = 1'b1;
    end
    if (state_q == StClear) begin
      vreg_d[cnt_q] = '0;
      busy_d[cnt_q] = 1'b0;
      if (pclr_ok[cnt_q] && !(P0_HARDWIRED && (cnt_q == '0))) begin
        preg_d[cnt_q[PAW-1:0]] = '0;
      end
    end
  end

  // Read ports
  always_comb begin
    v_rdata_d = '0;
    p_rdata_d = '0;
    for (int i = 0; i < NR_VREAD; i++) begin
      if (vaddr_ok[v_raddr[i]]) begin
`ifdef UVE_RF_BYPASS_EN
        v_rdata_d[i*VLEN +: VLEN] = vreg_wr[v_raddr[i]];
`else
        v_rdata_d[i*VLEN +: VLEN] = vreg_q[v_raddr[i]];
`endif
      end
    end
    for (int i = 0; i < NR_PREAD; i++) begin
      if (paddr_ok[p_raddr[i]]) begin
`ifdef UVE_RF_BYPASS_EN
        p_rdata_d[i*PLEN +: PLEN] = preg_wr[p_raddr[i]];
`else
        p_rdata_d[i*PLEN +: PLEN] = preg_q[p_raddr[i]];
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      busy_q    <= '0;
      v_rdata_q <= '0;
      p_rdata_q <= '0;
      for (int k = 0; k < NR_VREGS; k++) begin
        vreg_q[k] <= '0;
      end
      for (int k = 0; k < NR_PREGS; k++) begin
        preg_q[k] <= {PLEN{(k == 0) && P0_HARDWIRED}};
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      v_rdata_q <= v_rdata_d;
      p_rdata_q <= p_rdata_d;
      vreg_q    <= vreg_d;
      preg_q    <= preg_d;
    end
  end

  assign v_rdata_o = v_rdata_q;
  assign p_rdata_o = p_rdata_q;
  assign v_busy_o  = busy_q;

endmodule

// File: tb/tb_uve_regfile_banked.sv
// Directed bench for uve_regfile_banked (default parameters) against an array-level
// reference model; every cycle is compared, plus hand-computed literal expectations.
module tb_uve_regfile_banked;

  localparam int NV = 32;
  localparam int NP = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [14:0]  v_raddr;
  logic [767:0] v_rdata;
  logic [7:0]   p_raddr;
  logic [63:0]  p_rdata;
  logic [1:0]   v_wvalid;
  logic         w_ready;
  logic [9:0]   v_waddr;
  logic [511:0] v_wdata;
  logic [63:0]  v_wbe;
  logic [1:0]   v_wlast;
  logic [1:0]   p_we;
  logic [7:0]   p_waddr;
  logic [63:0]  p_wdata;
  logic         busy_set;
  logic [4:0]   busy_set_addr;
  logic [31:0]  v_busy;
  logic         clr_req;
  logic         clr_busy;
  logic         clr_done;

  always #5 clk = ~clk;

  uve_regfile_banked dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .v_raddr_i       (v_raddr),
    .v_rdata_o       (v_rdata),
    .p_raddr_i       (p_raddr),
    .p_rdata_o       (p_rdata),
    .v_wvalid_i      (v_wvalid),
    .w_ready_o       (w_ready),
    .v_waddr_i       (v_waddr),
    .v_wdata_i       (v_wdata),
    .v_wbe_i         (v_wbe),
    .v_wlast_i       (v_wlast),
    .p_we_i          (p_we),
    .p_waddr_i       (p_waddr),
    .p_wdata_i       (p_wdata),
    .busy_set_i      (busy_set),
    .busy_set_addr_i (busy_set_addr),
    .v_busy_o        (v_busy),
    .clr_req_i       (clr_req),
    .clr_busy_o      (clr_busy),
    .clr_done_o      (clr_done)
  );

  // Reference model: register contents, scoreboard and clear progress
  // (phase -1 = idle, 0..NV-1 = register being cleared, NV = done cycle).
  logic [255:0] mv [NV];
  logic [31:0]  mp [NP];
  logic [31:0]  mbusy;
  int           phase;
  logic [255:0] exp_vr [3];
  logic [31:0]  exp_pr [2];

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic [255:0] nv [NV];
    logic [31:0]  np [NP];
    logic         ready;
    int           a;
    if (rst) begin
      for (int k = 0; k < NV; k++) mv[k] = '0;
      for (int k = 0; k < NP; k++) mp[k] = (k == 0) ? 32'hFFFF_FFFF : 32'h0;
      mbusy = '0;
      phase = -1;
      for (int i = 0; i < 3; i++) exp_vr[i] = '0;
      for (int i = 0; i < 2; i++) exp_pr[i] = '0;
      return;
    end
    ready = (phase < 0);
    nv = mv;
    np = mp;
    for (int j = 0; j < 2; j++) begin
      if (ready && v_wvalid[j]) begin
        a = int'(v_waddr[j*5 +: 5]);
        for (int b = 0; b < 32; b++)
          if (v_wbe[j*32 + b]) nv[a][b*8 +: 8] = v_wdata[j*256 + b*8 +: 8];
      end
      if (ready && p_we[j] && (p_waddr[j*4 +: 4] != 4'd0))
        np[int'(p_waddr[j*4 +: 4])] = p_wdata[j*32 +: 32];
    end
`ifdef UVE_RF_BYPASS_EN
    for (int i = 0; i < 3; i++) exp_vr[i] = nv[int'(v_raddr[i*5 +: 5])];
    for (int i = 0; i < 2; i++) exp_pr[i] = np[int'(p_raddr[i*4 +: 4])];
`else
    for (int i = 0; i < 3; i++) exp_vr[i] = mv[int'(v_raddr[i*5 +: 5])];
    for (int i = 0; i < 2; i++) exp_pr[i] = mp[int'(p_raddr[i*4 +: 4])];
`endif
    for (int j = 0; j < 2; j++)
      if (ready && v_wvalid[j] && v_wlast[j]) mbusy[int'(v_waddr[j*5 +: 5])] = 1'b0;
    if (ready && busy_set) mbusy[int'(busy_set_addr)] = 1'b1;
    mv = nv;
    mp = np;
    if (phase >= 0 && phase < NV) begin
      mv[phase]    = '0;
      mbusy[phase] = 1'b0;
      if (phase < NP && phase != 0) mp[phase] = '0;
      phase++;
    end else if (phase == NV) begin
      phase = -1;
    end else if (clr_req) begin
      phase = 0;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++)
      check($sformatf("v_rdata%0d", i), v_rdata[i*256 +: 256], exp_vr[i]);
    for (int i = 0; i < 2; i++)
      check($sformatf("p_rdata%0d", i), 256'(p_rdata[i*32 +: 32]), 256'(exp_pr[i]));
    check("v_busy", 256'(v_busy), 256'(mbusy));
    check("w_ready", 256'(w_ready), 256'(phase < 0));
    check("clr_busy", 256'(clr_busy), 256'(phase >= 0));
    check("clr_done", 256'(clr_done), 256'(phase == NV));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    v_wvalid      = '0;
    v_waddr       = '0;
    v_wdata       = '0;
    v_wbe         = '0;
    v_wlast       = '0;
    p_we          = '0;
    p_waddr       = '0;
    p_wdata       = '0;
    busy_set      = 1'b0;
    busy_set_addr = '0;
    clr_req       = 1'b0;
  endtask

  task automatic vwrite(input int p, input int a, input logic [255:0] d,
                        input logic [31:0] be, input logic last);
    v_wvalid[p]          = 1'b1;
    v_waddr[p*5 +: 5]    = 5'(a);
    v_wdata[p*256 +: 256] = d;
    v_wbe[p*32 +: 32]    = be;
    v_wlast[p]           = last;
  endtask

  task automatic pwrite(input int p, input int a, input logic [31:0] d);
    p_we[p]            = 1'b1;
    p_waddr[p*4 +: 4]  = 4'(a);
    p_wdata[p*32 +: 32] = d;
  endtask

  int nb;
  int done_at;

  initial begin
    rst = 1'b1;
    idle_inputs();
    v_raddr = '0;
    p_raddr = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    v_raddr[4:0] = 5'd5;
    p_raddr[3:0] = 4'd0;
    tick();
    check("reset_u5", v_rdata[255:0], '0);
    check("reset_p0", 256'(p_rdata[31:0]), 256'(32'hFFFF_FFFF));
    check("reset_busy", 256'(v_busy), '0);
    check("reset_ready", 256'(w_ready), 256'(1'b1));

    // Byte-enable merge on u3
    vwrite(0, 3, {32{8'hAA}}, 32'hFFFF_FFFF, 1'b0);
    tick();
    idle_inputs();
    vwrite(0, 3, {32{8'h55}}, 32'h0000_0001, 1'b0);
    tick();
    idle_inputs();
    v_raddr[4:0] = 5'd3;
    tick();
    check("u3_merge", v_rdata[255:0], {{31{8'hAA}}, 8'h55});

    // Two ports on u7: per-byte priority to port 1
    vwrite(0, 7, {32{8'h11}}, 32'h0000_00FF, 1'b0);
    vwrite(1, 7, {32{8'h22}}, 32'h0000_0F0F, 1'b0);
    tick();
    idle_inputs();
    v_raddr[9:5] = 5'd7;
    tick();
    check("u7_prio", v_rdata[511:256], {{20{8'h00}}, {4{8'h22}}, {4{8'h11}}, {4{8'h22}}});

    // Same-cycle read of a register being written
    vwrite(1, 3, {32{8'h77}}, 32'hFFFF_FFFF, 1'b0);
    v_raddr[14:10] = 5'd3;
    tick();
    idle_inputs();

    // Busy scoreboard on u9
    busy_set = 1'b1;
    busy_set_addr = 5'd9;
    tick();
    idle_inputs();
    check("busy_set", 256'(v_busy[9]), 256'(1'b1));
    vwrite(1, 9, {32{8'h9C}}, 32'hFFFF_FFFF, 1'b0);
    tick();
    idle_inputs();
    check("busy_nolast", 256'(v_busy[9]), 256'(1'b1));
    vwrite(0, 9, {32{8'h9D}}, 32'hFFFF_FFFF, 1'b1);
    tick();
    idle_inputs();
    check("busy_last", 256'(v_busy[9]), 256'(1'b0));
    busy_set = 1'b1;
    busy_set_addr = 5'd9;
    vwrite(0, 9, {32{8'h9E}}, 32'hFFFF_FFFF, 1'b1);
    tick();
    idle_inputs();
    check("busy_set_wins", 256'(v_busy[9]), 256'(1'b1));

    // Predicates: port priority, p0 hardwired, same-cycle read
    pwrite(0, 2, 32'hDEAD_BEEF);
    pwrite(1, 2, 32'h1234_5678);
    tick();
    idle_inputs();
    pwrite(0, 0, 32'h0000_0000);
    pwrite(1, 5, 32'hA5A5_0F0F);
    p_raddr = {4'd5, 4'd2};
    tick();
    idle_inputs();
    check("p2_prio", 256'(p_rdata[31:0]), 256'(32'h1234_5678));
    p_raddr = {4'd5, 4'd0};
    tick();
    check("p0_hardwired", 256'(p_rdata[31:0]), 256'(32'hFFFF_FFFF));
    check("p5_write", 256'(p_rdata[63:32]), 256'(32'hA5A5_0F0F));

    // Fill everything, then bulk clear
    for (int k = 0; k < NV; k++) begin
      vwrite(0, k, {32{8'(k + 1)}}, 32'hFFFF_FFFF, 1'b0);
      if (k < NP) pwrite(1, k, {4{8'(k + 1)}});
      busy_set = 1'b1;
      busy_set_addr = 5'(k);
      tick();
      idle_inputs();
    end
    nb = 0;
    done_at = 0;
    clr_req = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      v_raddr = {5'(c), 5'(c + 1), 5'(c + 16)};
      p_raddr = {4'(c), 4'(c + 1)};
      if (c == 5) begin
        vwrite(0, 4, {32{8'hEE}}, 32'hFFFF_FFFF, 1'b0);
        pwrite(1, 3, 32'hCAFE_F00D);
        busy_set = 1'b1;
        busy_set_addr = 5'd30;
      end
      tick();
      idle_inputs();
      if (clr_busy) nb++;
      if (clr_done && done_at == 0) done_at = c;
    end
    check("clr_busy_cycles", 256'(nb), 256'(33));
    check("clr_done_cycle", 256'(done_at), 256'(33));
    v_raddr = {5'd31, 5'd0, 5'd4};
    p_raddr = {4'd3, 4'd0};
    tick();
    check("u4_after_clr", v_rdata[255:0], '0);
    check("u31_after_clr", v_rdata[767:512], '0);
    check("p0_after_clr", 256'(p_rdata[31:0]), 256'(32'hFFFF_FFFF));
    check("p3_after_clr", 256'(p_rdata[63:32]), '0);
    check("busy_after_clr", 256'(v_busy), '0);
    for (int k = 0; k < NV; k++) begin
      v_raddr = {5'(k), 5'(k), 5'(k)};
      p_raddr = {4'(k), 4'(k)};
      tick();
    end

    // Reset in the middle of a clear (cnt = 10)
    vwrite(0, 20, {32{8'h3C}}, 32'hFFFF_FFFF, 1'b0);
    pwrite(0, 7, 32'h0BAD_CAFE);
    busy_set = 1'b1;
    busy_set_addr = 5'd25;
    tick();
    idle_inputs();
    clr_req = 1'b1;
    tick();
    idle_inputs();
    for (int c = 0; c < 10; c++) tick();
    v_raddr = {5'd0, 5'd0, 5'd20};
    p_raddr = {4'd0, 4'd7};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_clr_busy", 256'(clr_busy), 256'(1'b0));
    check("rst_clr_done", 256'(clr_done), 256'(1'b0));
    check("rst_ready", 256'(w_ready), 256'(1'b1));
    check("rst_busy", 256'(v_busy), '0);
    tick();
    check("u20_after_rst", v_rdata[255:0], '0);
    check("p7_after_rst", 256'(p_rdata[31:0]), '0);
    for (int c = 0; c < 4; c++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
